// File: rtl/freq_gate_counter_if.sv
// rtl/freq_gate_counter_if.sv - measured-signal input and latched-result bundle of the frequency gate counter
interface freq_gate_counter_if #(
  parameter int DIGITS = 4
);
  logic                  signal;
  logic                  range;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic                  res_range;
  logic                  valid;

  modport master (
    input  signal,
    output range,
    output bcd,
    output overflow,
    output res_range,
    output valid
  );

  modport slave (
    output signal,
    input  range,
    input  bcd,
    input  overflow,
    input  res_range,
    input  valid
  );
endinterface

// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - gated BCD edge counter with auto-ranging for the frequency meter
module freq_gate_counter #(
  parameter int DIGITS      = 4,
  parameter int GATE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  freq_gate_counter_if.master  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic {
    COUNT  = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic           s1;
  logic           s2;
  logic           s3;
  logic           edge_det;

  logic [TW-1:0]  timer;
  logic           gate_end;

  logic [W-1:0]   acc;
  logic           ovf;

  logic           range_q;
  logic           range_nxt;
  logic [W-1:0]   bcd_q;
  logic           overflow_q;
  logic           res_range_q;
  logic           valid_q;

  logic           latch;
  logic           count_en;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // s1/s2 resolve metastability; s3 only delays s2 for the rising-edge compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (timer == GATE_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign gate_end = (timer == GATE_LAST);

  always_comb begin
    range_nxt = range_q;
    if (ovf && !range_q) begin
      range_nxt = 1'b1;
    end else if (!ovf && range_q && (acc[W-1 -: 4] == 4'd0)) begin
      range_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COUNT: begin
        if (gate_end) begin
          state_nxt = (range_nxt != range_q) ? SETTLE : COUNT;
        end
      end
      SETTLE: begin
        if (gate_end) begin
          state_nxt = COUNT;
        end
      end
      default: state_nxt = COUNT;
    endcase
  end

  always_comb begin
    latch    = 1'b0;
    count_en = 1'b0;
    if (state == COUNT) begin
      latch    = gate_end;
      count_en = edge_det & ~gate_end;
    end
  end

  // A boundary-cycle edge seeds the next window so the window totals stay conserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (gate_end) begin
      acc <= edge_det ? W'(1) : W'(0);
      ovf <= 1'b0;
    end else if (count_en) begin
      if (acc == ALL_NINES) begin
        ovf <= 1'b1;
      end else begin
        acc <= bcd_inc(acc);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      res_range_q <= 1'b0;
      range_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= latch;
      if (latch) begin
        bcd_q       <= ovf ? ALL_NINES : acc;
        overflow_q  <= ovf;
        res_range_q <= range_q;
        range_q     <= range_nxt;
      end
    end
  end

  assign bus.range     = range_q;
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = overflow_q;
  assign bus.res_range = res_range_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb/tb_freq_gate_counter.sv - directed self-checking bench for freq_gate_counter
module tb_freq_gate_counter;

  localparam int DIGITS = 2;
  localparam int GATE   = 200;

  logic clk = 1'b0;
  logic reset;

  int   n_checks = 0;
  int   n_fail   = 0;

  int   gen_period = 8;
  int   gen_phase  = 0;
  logic gen_level  = 1'b0;

  always #5 clk = ~clk;

  freq_gate_counter_if #(.DIGITS(DIGITS)) bus ();

  freq_gate_counter #(
    .DIGITS      (DIGITS),
    .GATE_CYCLES (GATE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // signal source: periodic square wave, or a static level when gen_period is 0
  initial begin
    bus.signal = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (gen_period == 0) begin
        bus.signal = gen_level;
      end else begin
        gen_phase  = (gen_phase + 1) % gen_period;
        bus.signal = (gen_phase < gen_period / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!bus.valid && cyc < max);
  endtask

  task automatic pulse();
    gen_level = 1'b1;
    step(2);
    gen_level = 1'b0;
    step(2);
  endtask

  initial begin
    int c;
    int nv;
    logic t1_ok;

    reset = 1'b1;
    step(3);
    check("rst_bcd", bus.bcd, 8'h00);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_range", bus.range, 1'b0);

    // 1: period 8 -> about 25 edges per window
    @(negedge clk);
    reset = 1'b0;
    wait_valid(260, c);
    check("t1_latency", c, 200);
    t1_ok = (bus.bcd >= 8'h24) && (bus.bcd <= 8'h26);
    check("t1_bcd_25pm1", t1_ok, 1'b1);
    check("t1_overflow", bus.overflow, 1'b0);
    check("t1_res_range", bus.res_range, 1'b0);
    check("t1_range", bus.range, 1'b0);
    step(1);
    check("t1_valid_width", bus.valid, 1'b0);

    // 2: period 2 -> 100 edges in a steady window, overflow and range up
    reset      = 1'b1;
    gen_period = 2;
    step(2);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(260, c);
    check("t2_w1_latency", c, 200);
    check("t2_w1_no_ovf", bus.overflow, 1'b0);
    wait_valid(260, c);
    check("t2_w2_latency", c, 200);
    check("t2_bcd", bus.bcd, 8'h99);
    check("t2_overflow", bus.overflow, 1'b1);
    check("t2_res_range", bus.res_range, 1'b0);
    check("t2_range_up", bus.range, 1'b1);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.valid) nv++;
    end
    check("t2_settle_quiet", nv, 0);

    // 3: period 40 in range 1 -> 5 edges, range down, one silent window
    gen_period = 40;
    wait_valid(400, c);
    check("t2_settle_skip", c, 300);
    check("t3_bcd", bus.bcd, 8'h05);
    check("t3_overflow", bus.overflow, 1'b0);
    check("t3_res_range", bus.res_range, 1'b1);
    check("t3_range_down", bus.range, 1'b0);
    wait_valid(450, c);
    check("t3_settle_skip", c, 400);
    check("t3_bcd_r0", bus.bcd, 8'h05);
    check("t3_res_range_r0", bus.res_range, 1'b0);

    // 4: edge landing on the gate_end cycle belongs to the next window
    gen_period = 0;
    gen_level  = 1'b0;
    wait_valid(260, c);
    check("t4_quiet_latency", c, 200);
    pulse();
    pulse();
    pulse();
    step(185);
    gen_level = 1'b1;
    wait_valid(10, c);
    check("t4_latch_pos", c, 3);
    check("t4_old_bcd", bus.bcd, 8'h03);
    gen_level = 1'b0;
    step(2);
    pulse();
    pulse();
    wait_valid(260, c);
    check("t4_new_latency", c, 190);
    check("t4_new_bcd", bus.bcd, 8'h03);

    // 5: async reset at clk 120 of a window
    pulse();
    pulse();
    step(112);
    reset = 1'b1;
    #1;
    check("t5_bcd_async", bus.bcd, 8'h00);
    check("t5_valid_async", bus.valid, 1'b0);
    check("t5_overflow_async", bus.overflow, 1'b0);
    check("t5_res_range_async", bus.res_range, 1'b0);
    check("t5_range_async", bus.range, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1);
    pulse();
    wait_valid(260, c);
    check("t5_latency", c, 195);
    check("t5_bcd_fresh", bus.bcd, 8'h01);
    check("t5_overflow", bus.overflow, 1'b0);

    // 6: signal held high -> zero counts, valid every window
    reset     = 1'b1;
    gen_level = 1'b1;
    step(3);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(260, c);
    check("t6_w1_latency", c, 200);
    wait_valid(260, c);
    check("t6_w2_latency", c, 200);
    check("t6_w2_bcd", bus.bcd, 8'h00);
    check("t6_w2_overflow", bus.overflow, 1'b0);
    wait_valid(260, c);
    check("t6_w3_latency", c, 200);
    check("t6_w3_bcd", bus.bcd, 8'h00);
    step(1);
    check("t6_valid_width", bus.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
